bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one byte-wide memory port and one GPIO port among N_CORES cores.
//  Speaks the core-side grant_request/grant_given handshake and runs each granted transfer to completion.
//  Drives a 256-byte synchronous RAM (address[8]=0) or the GPIO block (address[8]=1).
//  Sits between the core instances and the shared RAM/GPIO at the top level.
// PARAMETERS
//  N_CORES  2  number of requesting cores (2..8)
// PORTS
//  clk         in   1          system clock; all state on posedge
//  reset       in   1          asynchronous, active-low reset
//  req         in   N_CORES    per-core grant_request
//  req_rw      in   N_CORES    per-core rw; 1=write, 0=read
//  req_addr    in   9*N_CORES  per-core address; core i at [9i+8:9i]; bit 8 selects GPIO
//  req_wdata   in   8*N_CORES  per-core data_out; core i at [8i+7:8i]
//  grant       out  N_CORES    per-core grant_given; one-hot or zero
//  rdata       out  8          read data broadcast to all cores; valid while grant is high
//  mem_en      out  1          RAM access strobe
//  mem_we      out  1          RAM write enable (only with mem_en)
//  mem_addr    out  8          RAM address
//  mem_wdata   out  8          RAM write data
//  mem_rdata   in   8          RAM read data; valid the cycle after mem_en
//  gpio_en     out  1          GPIO access strobe
//  gpio_we     out  1          GPIO write enable
//  gpio_addr   out  8          GPIO register address
//  gpio_wdata  out  8          GPIO write data
//  gpio_rdata  in   8          GPIO read data; valid the cycle after gpio_en
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, grant=0, rdata=0, all mem_*/gpio_* outputs 0, last=N_CORES-1.
//   Asserted mid-transfer: transfer is abandoned; no write strobe is issued after reset asserts.
//  FSM: IDLE -> ACCESS -> CAPTURE -> GRANT -> IDLE. All outputs are registered.
//   IDLE:    if any req, pick the winner w (first set bit scanning from last+1 mod N_CORES upward, wrapping).
//            Latch sel=w, rw, addr, and wdata. last<=w. Go to ACCESS. With no req, stay idle.
//   ACCESS:  one cycle. addr[8]=0: mem_en=1, mem_we=rw, mem_addr=addr[7:0], mem_wdata=wdata.
//            addr[8]=1: same pattern on gpio_*. Only one port is strobed. Strobes are exactly 1 cycle.
//   CAPTURE: strobes drop. Register rdata <= mem_rdata or gpio_rdata (port chosen by addr[8]).
//            On a write, rdata holds its previous value. Set grant[sel]=1. Go to GRANT.
//   GRANT:   grant[sel] high for exactly one cycle; the core samples rdata and drops req at this edge.
//            Next: grant=0, go to IDLE.
//  Latency: req sampled high in IDLE at edge E0 -> strobe during E0..E1 -> grant high E2..E3.
//   A transfer takes 3 cycles plus 1 IDLE cycle. Back-to-back transfers repeat every 4 cycles.
//  Writes also complete with a grant pulse; a store is finished when grant is seen.
//  Fairness: with all cores requesting continuously, grants rotate 0,1,..,N-1,0. No core waits more than N-1 transfers.
//  Requests are sampled only in IDLE. Changes to req/addr/wdata after latching are ignored until the next IDLE.
//  A req that drops before its grant is still completed; the grant pulse is harmless.
//  A req still high in IDLE right after its own grant (same core) is treated as a new request.
//   It still loses to any other requester under rotation.
//  Address 9'h0FF and 9'h1FF map to RAM 0xFF and GPIO 0xFF; there is no wrap or translation.
//  grant is never multi-hot. mem_en and gpio_en are never high together.
// TESTING
//  1. Reset hold then release, no req -> grant=0, mem_en=0, gpio_en=0, rdata=0 for 20 cycles.
//  2. Core0 reads addr 9'h010, RAM[0x10]=8'hA5 -> mem_en 1 cycle, mem_addr=8'h10, mem_we=0.
//     Then grant[0] 1 cycle, 2 cycles later, with rdata=8'hA5.
//  3. Core1 writes 8'h3C to 9'h105 -> gpio_en=1, gpio_we=1, gpio_addr=8'h05, gpio_wdata=8'h3C.
//     mem_en stays 0; grant[1] pulses.
//  4. Core0 and core1 request together continuously after reset -> grant order 0,1,0,1.
//     Grants are 4 cycles apart.
//  5. Assert reset during ACCESS of a write to 9'h020 -> mem_en/mem_we drop immediately.
//     No grant issues. After release, idle with last=N_CORES-1 (core0 wins next).
//  6. Core0 fetches a 4-byte instruction from 0x00..0x03 holding 8'h20,8'h22,8'h00,8'h20.
//     Core builds IR=32'h20220020 over 4 grants.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin sequencer sharing one byte-wide RAM port and one GPIO port among N_CORES cores.
// Each grant covers exactly one single-byte transfer: IDLE -> ACCESS -> CAPTURE -> GRANT.
module bus_arbiter #(
  parameter int N_CORES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CORES-1:0]     req,
  input  logic [N_CORES-1:0]     req_rw,
  input  logic [9*N_CORES-1:0]   req_addr,
  input  logic [8*N_CORES-1:0]   req_wdata,
  output logic [N_CORES-1:0]     grant,
  output logic [7:0]             rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic                   gpio_en,
  output logic                   gpio_we,
  output logic [7:0]             gpio_addr,
  output logic [7:0]             gpio_wdata,
  input  logic [7:0]             gpio_rdata
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    GRANT   = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   sel_q;
  logic [IDX_W-1:0]   last_q;
  logic               rw_q;
  logic               gpio_sel_q;
  logic [N_CORES-1:0] grant_q;
  logic [7:0]         rdata_q;
  logic               mem_en_q;
  logic               mem_we_q;
  logic [7:0]         mem_addr_q;
  logic [7:0]         mem_wdata_q;
  logic               gpio_en_q;
  logic               gpio_we_q;
  logic [7:0]         gpio_addr_q;
  logic [7:0]         gpio_wdata_q;

  logic [IDX_W-1:0]   sel_d;
  logic               win_rw_d;
  logic [8:0]         win_addr_d;
  logic [7:0]         win_wdata_d;

  // First requester strictly after l, wrapping; the closest candidate is evaluated last so it wins.
  function automatic logic [IDX_W-1:0] rr_next(input logic [N_CORES-1:0] r,
                                               input logic [IDX_W-1:0]   l);
    logic [IDX_W-1:0] w;
    int               idx;
    w = l;
    for (int k = N_CORES; k >= 1; k--) begin
      idx = (int'(l) + k) % N_CORES;
      if (r[idx]) w = IDX_W'(idx);
    end
    return w;
  endfunction

  always_comb begin
    sel_d       = rr_next(req, last_q);
    win_rw_d    = 1'b0;
    win_addr_d  = '0;
    win_wdata_d = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (IDX_W'(i) == sel_d) begin
        win_rw_d    = req_rw[i];
        win_addr_d  = req_addr[9*i +: 9];
        win_wdata_d = req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_q       <= IDX_W'(N_CORES - 1);
      rw_q         <= 1'b0;
      gpio_sel_q   <= 1'b0;
      grant_q      <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      gpio_en_q    <= 1'b0;
      gpio_we_q    <= 1'b0;
      gpio_addr_q  <= '0;
      gpio_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            sel_q      <= sel_d;
            last_q     <= sel_d;
            rw_q       <= win_rw_d;
            gpio_sel_q <= win_addr_d[8];
            // Strobe is launched on the latching edge so it is visible for the whole ACCESS cycle.
            if (win_addr_d[8]) begin
              gpio_en_q    <= 1'b1;
              gpio_we_q    <= win_rw_d;
              gpio_addr_q  <= win_addr_d[7:0];
              gpio_wdata_q <= win_wdata_d;
            end else begin
              mem_en_q     <= 1'b1;
              mem_we_q     <= win_rw_d;
              mem_addr_q   <= win_addr_d[7:0];
              mem_wdata_q  <= win_wdata_d;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          gpio_en_q <= 1'b0;
          gpio_we_q <= 1'b0;
          state_q   <= CAPTURE;
        end
        CAPTURE: begin
          if (!rw_q) rdata_q <= gpio_sel_q ? gpio_rdata : mem_rdata;
          grant_q <= N_CORES'(1) << sel_q;
          state_q <= GRANT;
        end
        GRANT: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign rdata      = rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign gpio_en    = gpio_en_q;
  assign gpio_we    = gpio_we_q;
  assign gpio_addr  = gpio_addr_q;
  assign gpio_wdata = gpio_wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus a randomized run against a transfer-level model
// that knows only the arbitration rule, the 4-cycle transfer timing and the memory contents.
module tb_bus_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_rw;
  logic [9*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   grant;
  logic [7:0]     rdata;
  logic           mem_en, mem_we, gpio_en, gpio_we;
  logic [7:0]     mem_addr, mem_wdata, mem_rdata, gpio_addr, gpio_wdata, gpio_rdata;

  logic [7:0]     ram_mem  [256];
  logic [7:0]     gpio_mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_CORES(N)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gpio_en(gpio_en), .gpio_we(gpio_we), .gpio_addr(gpio_addr),
    .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata)
  );

  // Synchronous RAM and GPIO register file: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram_mem[mem_addr];
      if (mem_we) ram_mem[mem_addr] = mem_wdata;
    end
    if (gpio_en) begin
      gpio_rdata <= gpio_mem[gpio_addr];
      if (gpio_we) gpio_mem[gpio_addr] = gpio_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic r, input logic rw,
                          input logic [8:0] a, input logic [7:0] d);
    req[i]             = r;
    req_rw[i]          = rw;
    req_addr[9*i +: 9] = a;
    req_wdata[8*i +: 8] = d;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int l);
    for (int k = 1; k <= N; k++) if (r[(l + k) % N]) return (l + k) % N;
    return l;
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) begin
      tick;
      checks++;
      if ({grant, rdata, mem_en, mem_we, mem_addr, mem_wdata,
           gpio_en, gpio_we, gpio_addr, gpio_wdata} !== '0)
        begin errors++; $display("FAIL reset_outputs: grant=%b rdata=%h mem_en=%b gpio_en=%b required all zero",
                                 grant, rdata, mem_en, gpio_en); end
    end
    reset = 1'b1;
    repeat (20) begin
      tick;
      checks++;
      if ({grant, mem_en, gpio_en, rdata} !== '0)
        begin errors++; $display("FAIL idle_after_reset: grant=%b mem_en=%b gpio_en=%b rdata=%h required 0",
                                 grant, mem_en, gpio_en, rdata); end
    end
  endtask

  task automatic test_ram_read;
    int t = 0;
    ram_mem[8'h10] = 8'hA5;
    set_core(0, 1'b1, 1'b0, 9'h010, 8'h00);
    while (!mem_en && t < 10) begin tick; t++; end
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10 || gpio_en !== 1'b0)
      begin errors++; $display("FAIL read_strobe: en=%b we=%b addr=%h gpio_en=%b required 1 0 10 0",
                               mem_en, mem_we, mem_addr, gpio_en); end
    tick;
    checks++;
    if (mem_en !== 1'b0 || grant !== '0)
      begin errors++; $display("FAIL read_strobe_width: mem_en=%b grant=%b required 0 0", mem_en, grant); end
    tick;
    checks++;
    if (grant !== 3'b001 || rdata !== 8'hA5)
      begin errors++; $display("FAIL read_grant: grant=%b rdata=%h required 001 a5", grant, rdata); end
    set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
    tick;
    checks++;
    if (grant !== '0)
      begin errors++; $display("FAIL read_grant_width: grant=%b required 000", grant); end
    repeat (2) tick;
  endtask

  task automatic test_gpio_write;
    int t = 0;
    set_core(1, 1'b1, 1'b1, 9'h105, 8'h3C);
    while (!(gpio_en || mem_en) && t < 10) begin tick; t++; end
    checks++;
    if (gpio_en !== 1'b1 || gpio_we !== 1'b1 || gpio_addr !== 8'h05 || gpio_wdata !== 8'h3C || mem_en !== 1'b0)
      begin errors++; $display("FAIL gpio_write_strobe: en=%b we=%b addr=%h data=%h mem_en=%b required 1 1 05 3c 0",
                               gpio_en, gpio_we, gpio_addr, gpio_wdata, mem_en); end
    tick;
    checks++;
    if (gpio_en !== 1'b0 || mem_en !== 1'b0)
      begin errors++; $display("FAIL gpio_strobe_width: gpio_en=%b mem_en=%b required 0 0", gpio_en, mem_en); end
    tick;
    checks++;
    if (grant !== 3'b010 || gpio_mem[8'h05] !== 8'h3C)
      begin errors++; $display("FAIL gpio_write_grant: grant=%b gpio[5]=%h required 010 3c",
                               grant, gpio_mem[8'h05]); end
    set_core(1, 1'b0, 1'b0, 9'h000, 8'h00);
    repeat (3) tick;
  endtask

  task automatic test_boundary;
    int t = 0;
    set_core(1, 1'b1, 1'b1, 9'h1FF, 8'h5A);
    while (!(gpio_en || mem_en) && t < 10) begin tick; t++; end
    checks++;
    if (gpio_en !== 1'b1 || gpio_addr !== 8'hFF || mem_en !== 1'b0)
      begin errors++; $display("FAIL boundary_gpio: gpio_en=%b addr=%h mem_en=%b required 1 ff 0",
                               gpio_en, gpio_addr, mem_en); end
    repeat (2) tick;
    set_core(1, 1'b0, 1'b0, 9'h000, 8'h00);
    repeat (2) tick;
    ram_mem[8'hFF] = 8'hC3;
    set_core(0, 1'b1, 1'b0, 9'h0FF, 8'h00);
    t = 0;
    while (!(gpio_en || mem_en) && t < 10) begin tick; t++; end
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 8'hFF || gpio_en !== 1'b0)
      begin errors++; $display("FAIL boundary_ram: mem_en=%b addr=%h gpio_en=%b required 1 ff 0",
                               mem_en, mem_addr, gpio_en); end
    repeat (2) tick;
    checks++;
    if (grant !== 3'b001 || rdata !== 8'hC3)
      begin errors++; $display("FAIL boundary_read: grant=%b rdata=%h required 001 c3", grant, rdata); end
    set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
    repeat (2) tick;
    set_core(2, 1'b1, 1'b1, 9'h0FF, 8'h11);
    t = 0;
    while (grant === '0 && t < 10) begin tick; t++; end
    checks++;
    if (grant !== 3'b100 || rdata !== 8'hC3 || ram_mem[8'hFF] !== 8'h11)
      begin errors++; $display("FAIL write_holds_rdata: grant=%b rdata=%h ram=%h required 100 c3 11",
                               grant, rdata, ram_mem[8'hFF]); end
    set_core(2, 1'b0, 1'b0, 9'h000, 8'h00);
    repeat (3) tick;
  endtask

  task automatic test_rotation;
    int who [4];
    int when [4];
    int n = 0;
    int cyc = 0;
    do_reset;
    set_core(0, 1'b1, 1'b0, 9'h001, 8'h00);
    set_core(1, 1'b1, 1'b0, 9'h002, 8'h00);
    while (n < 4 && cyc < 40) begin
      tick;
      cyc++;
      if (grant !== '0) begin
        who[n] = -1;
        for (int i = 0; i < N; i++) if (grant[i] === 1'b1) who[n] = i;
        when[n] = cyc;
        checks++;
        if ($countones(grant) != 1)
          begin errors++; $display("FAIL rotation_onehot: grant=%b required one-hot", grant); end
        n++;
      end
    end
    req = '0;
    checks++;
    if (n != 4)
      begin errors++; $display("FAIL rotation_count: got %0d grants required 4", n); end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (who[k] != k % 2)
        begin errors++; $display("FAIL rotation_order: grant %0d went to core %0d required %0d", k, who[k], k % 2); end
      if (k > 0) begin
        checks++;
        if (when[k] - when[k-1] != 4)
          begin errors++; $display("FAIL rotation_spacing: %0d cycles required 4", when[k] - when[k-1]); end
      end
    end
    repeat (4) tick;
  endtask

  task automatic test_reset_mid;
    int t = 0;
    ram_mem[8'h20] = 8'h77;
    set_core(0, 1'b1, 1'b1, 9'h020, 8'hEE);
    while (!mem_en && t < 10) begin tick; t++; end
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1)
      begin errors++; $display("FAIL midreset_access: mem_en=%b mem_we=%b required 1 1", mem_en, mem_we); end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0)
      begin errors++; $display("FAIL midreset_drop: mem_en=%b mem_we=%b required 0 0", mem_en, mem_we); end
    req = '0;
    repeat (2) tick;
    reset = 1'b1;
    repeat (3) begin
      tick;
      checks++;
      if (grant !== '0 || ram_mem[8'h20] !== 8'h77)
        begin errors++; $display("FAIL midreset_no_write: grant=%b ram=%h required 000 77", grant, ram_mem[8'h20]); end
    end
    set_core(0, 1'b1, 1'b0, 9'h030, 8'h00);
    set_core(1, 1'b1, 1'b0, 9'h031, 8'h00);
    t = 0;
    while (grant === '0 && t < 10) begin tick; t++; end
    checks++;
    if (grant !== 3'b001)
      begin errors++; $display("FAIL midreset_last: grant=%b required 001", grant); end
    req = '0;
    repeat (4) tick;
  endtask

  task automatic test_fetch;
    logic [31:0] ir = '0;
    int t;
    ram_mem[0] = 8'h20; ram_mem[1] = 8'h22; ram_mem[2] = 8'h00; ram_mem[3] = 8'h20;
    for (int b = 0; b < 4; b++) begin
      set_core(0, 1'b1, 1'b0, 9'(b), 8'h00);
      t = 0;
      while (grant[0] !== 1'b1 && t < 10) begin tick; t++; end
      ir = {ir[23:0], rdata};
      set_core(0, 1'b0, 1'b0, 9'h000, 8'h00);
      tick;
    end
    checks++;
    if (ir !== 32'h20220020)
      begin errors++; $display("FAIL fetch_ir: got %h required 20220020", ir); end
    repeat (3) tick;
  endtask

  task automatic test_random;
    logic [7:0]   ref_ram  [256];
    logic [7:0]   ref_gpio [256];
    int           cyc = 0, free_cyc = 0, grant_cyc = -1, win = 0, last_m = N - 1;
    logic         w_rw = 1'b0;
    logic [8:0]   w_addr = '0;
    logic [7:0]   w_data = '0, rd_val = '0, exp_rdata = '0;
    logic [N-1:0] exp_grant;
    do_reset;
    for (int a = 0; a < 256; a++) begin
      ram_mem[a]  = 8'($urandom); ref_ram[a]  = ram_mem[a];
      gpio_mem[a] = 8'($urandom); ref_gpio[a] = gpio_mem[a];
    end
    repeat (800) begin
      tick;
      cyc++;
      if (cyc >= free_cyc && req != '0) begin
        win    = rr_pick(req, last_m);
        last_m = win;
        w_rw   = req_rw[win];
        w_addr = req_addr[9*win +: 9];
        w_data = req_wdata[8*win +: 8];
        checks++;
        if (w_addr[8]) begin
          if (gpio_en !== 1'b1 || gpio_we !== w_rw || gpio_addr !== w_addr[7:0] ||
              (w_rw && gpio_wdata !== w_data) || mem_en !== 1'b0)
            begin errors++; $display("FAIL rand_gpio_strobe: cyc %0d en=%b we=%b addr=%h data=%h required 1 %b %h %h",
                                     cyc, gpio_en, gpio_we, gpio_addr, gpio_wdata, w_rw, w_addr[7:0], w_data); end
          if (w_rw) ref_gpio[w_addr[7:0]] = w_data; else rd_val = ref_gpio[w_addr[7:0]];
        end else begin
          if (mem_en !== 1'b1 || mem_we !== w_rw || mem_addr !== w_addr[7:0] ||
              (w_rw && mem_wdata !== w_data) || gpio_en !== 1'b0)
            begin errors++; $display("FAIL rand_mem_strobe: cyc %0d en=%b we=%b addr=%h data=%h required 1 %b %h %h",
                                     cyc, mem_en, mem_we, mem_addr, mem_wdata, w_rw, w_addr[7:0], w_data); end
          if (w_rw) ref_ram[w_addr[7:0]] = w_data; else rd_val = ref_ram[w_addr[7:0]];
        end
        free_cyc  = cyc + 4;
        grant_cyc = cyc + 2;
      end else begin
        checks++;
        if (mem_en !== 1'b0 || gpio_en !== 1'b0 || mem_we !== 1'b0 || gpio_we !== 1'b0)
          begin errors++; $display("FAIL rand_no_strobe: cyc %0d mem_en=%b gpio_en=%b required 0 0",
                                   cyc, mem_en, gpio_en); end
      end
      exp_grant = (cyc == grant_cyc) ? (N'(1) << win) : '0;
      if (cyc == grant_cyc && !w_rw) exp_rdata = rd_val;
      checks++;
      if (grant !== exp_grant || rdata !== exp_rdata)
        begin errors++; $display("FAIL rand_grant: cyc %0d grant=%b rdata=%h required %b %h",
                                 cyc, grant, rdata, exp_grant, exp_rdata); end
      for (int i = 0; i < N; i++) begin
        if (cyc == grant_cyc && i == win) begin
          if ($urandom_range(1, 0) == 1)
            set_core(i, 1'b1, 1'($urandom), 9'($urandom), 8'($urandom));
          else
            req[i] = 1'b0;
        end else if (cyc < grant_cyc && i == win) begin
          case ($urandom_range(9, 0))
            0:       req[i] = 1'b0;
            1, 2:    if (req[i]) set_core(i, 1'b1, 1'($urandom), 9'($urandom), 8'($urandom));
            default: ;
          endcase
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          set_core(i, 1'b1, 1'($urandom), 9'($urandom), 8'($urandom));
        end
      end
    end
    req = '0;
    repeat (5) tick;
  endtask

  initial begin
    reset = 1'b0;
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    test_reset;
    test_ram_read;
    test_gpio_write;
    test_boundary;
    test_rotation;
    test_reset_mid;
    test_fetch;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
